// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Byte-stream boot loader. Receives a framed program image
//               (length, 16-bit words, checksum) and writes it word by word
//               into instruction memory. The CPU stays in reset until a load
//               completes with a good checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_start,
  input  logic [7:0]            io_rxData,
  input  logic                  io_rxValid,
  output logic                  io_rxReady,
  output logic [ADDR_WIDTH-1:0] io_addr,
  output logic [WORD_WIDTH-1:0] io_instrIn,
  output logic                  io_instrWrite,
  output logic                  io_busy,
  output logic                  io_done,
  output logic                  io_error,
  output logic                  io_cpuHold
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_WR   = 3'd4,
    S_CHK  = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic [ADDR_WIDTH-1:0] r_last_idx;
  logic [7:0]            r_sum;
  logic [7:0]            r_hi;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0] r_instr_in;
  logic                  r_instr_write;
  logic                  r_done;
  logic                  r_error;
  logic                  r_cpu_hold;

  logic                  w_rx_ready;
  logic                  w_fire;
  logic [7:0]            w_sum_next;
  logic [ADDR_WIDTH-1:0] w_len_last;

  assign w_rx_ready = (r_state == S_LEN) || (r_state == S_HI) ||
                      (r_state == S_LO)  || (r_state == S_CHK);
  assign w_fire     = w_rx_ready && io_rxValid;
  assign w_sum_next = r_sum + io_rxData;

  // A length byte of zero encodes the full 2^ADDR_WIDTH-word image.
  assign w_len_last = (io_rxData == 8'd0) ? {ADDR_WIDTH{1'b1}}
                                          : ADDR_WIDTH'(io_rxData - 8'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_word_idx    <= '0;
      r_last_idx    <= '0;
      r_sum         <= '0;
      r_hi          <= '0;
      r_addr        <= '0;
      r_instr_in    <= '0;
      r_instr_write <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_cpu_hold    <= 1'b1;
    end else begin
      r_instr_write <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_start) begin
            r_state    <= S_LEN;
            r_word_idx <= '0;
            r_sum      <= '0;
            r_cpu_hold <= 1'b1;
          end
        end
        S_LEN: begin
          if (w_fire) begin
            r_last_idx <= w_len_last;
            r_sum      <= io_rxData;
            r_state    <= S_HI;
          end
        end
        S_HI: begin
          if (w_fire) begin
            r_hi    <= io_rxData;
            r_sum   <= w_sum_next;
            r_state <= S_LO;
          end
        end
        S_LO: begin
          // Launch the write so the strobe is visible for exactly the WR cycle.
          if (w_fire) begin
            r_sum         <= w_sum_next;
            r_addr        <= r_word_idx;
            r_instr_in    <= WORD_WIDTH'({r_hi, io_rxData});
            r_instr_write <= 1'b1;
            r_state       <= S_WR;
          end
        end
        S_WR: begin
          if (r_word_idx == r_last_idx) begin
            r_state <= S_CHK;
          end else begin
            r_word_idx <= r_word_idx + 1'b1;
            r_state    <= S_HI;
          end
        end
        S_CHK: begin
          if (w_fire) begin
            if (w_sum_next == 8'd0) begin
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
              r_state    <= S_DONE;
            end else begin
              r_error    <= 1'b1;
              r_cpu_hold <= 1'b1;
              r_state    <= S_ERR;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (io_start) begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_word_idx <= '0;
            r_sum      <= '0;
            r_state    <= S_LEN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_rxReady    = w_rx_ready;
  assign io_busy       = w_rx_ready || (r_state == S_WR);
  assign io_addr       = r_addr;
  assign io_instrIn    = r_instr_in;
  assign io_instrWrite = r_instr_write;
  assign io_done       = r_done;
  assign io_error      = r_error;
  assign io_cpuHold    = r_cpu_hold;

endmodule
`default_nettype wire
